refresh_scheduler: RTL and testbench
====================================

Name: refresh_scheduler

Overview:
Per-rank DDR refresh timer and postponement tracker for the memory controller core, generalised to C_CS_WIDTH ranks. It replaces the single-rank 1024 kHz refresh controller and runs entirely in the core_clk domain. It counts tREFI per rank, accumulates owed refreshes up to the JEDEC postponement limit, and raises normal and urgent requests to main_control. It then enforces tRFC blocking after each acknowledged REF. Rank counters are staggered so ranks do not refresh together.

Parameters:
C_CS_WIDTH, 1, number of ranks (1..8)
C_CNT_WIDTH, 16, width of tREFI/tRFC counters
C_TREFI_CYCLES, 6240, tREFI in core_clk cycles (2..2^C_CNT_WIDTH-1)
C_TRFC_CYCLES, 128, tRFC in core_clk cycles (1..C_TREFI_CYCLES-1)
C_MAX_POSTPONE, 8, max owed refreshes per rank (1..15)
C_URGENT_THRESH, 7, owed count at which urgent asserts (1..C_MAX_POSTPONE)

Ports:
core_clk  input  1  core clock
core_arstn  input  1  asynchronous active-low reset
enable  input  1  refresh tracking enable (driven by ddr_init_done / not-in-self-refresh)
ref_ack  input  C_CS_WIDTH  one-cycle pulse per rank: REF issued to that rank this cycle
ref_req  output  C_CS_WIDTH  rank owes at least one refresh and is not in tRFC
ref_urgent  output  C_CS_WIDTH  owed count >= C_URGENT_THRESH; scheduler must drain
rank_busy  output  C_CS_WIDTH  rank inside tRFC window; no commands allowed
pending  output  4*C_CS_WIDTH  owed count per rank, rank i at [4i+3:4i]
overflow  output  C_CS_WIDTH  sticky: tREFI tick arrived with pending == C_MAX_POSTPONE

Behaviour:
- Reset (async, core_arstn low): all outputs 0; pending 0; interval counters, tRFC counters and enable_q cleared.
- enable_q registers enable. A rising edge (enable & ~enable_q) loads each rank i interval counter with C_TREFI_CYCLES-1 - i*(C_TREFI_CYCLES/C_CS_WIDTH). This is the stagger.
- Interval counter, while enable: decrements each cycle. At 0 it generates tick[i] and reloads C_TREFI_CYCLES-1. The first tick for rank 0 is therefore exactly C_TREFI_CYCLES cycles after the enable rise.
- enable low: interval counters hold, and pending is cleared to 0 on the cycle enable_q falls (entry to self-refresh/reinit). An in-progress tRFC window still runs to completion. overflow is not cleared.
- ack_ok[i] = ref_ack[i] & ref_req[i]. An ack while ref_req is low is ignored: no state change.
- Pending update per cycle, computed from registered state:
  - tick only: pending+1. If pending == C_MAX_POSTPONE, hold and set overflow[i].
  - ack_ok only: pending-1.
  - tick and ack_ok together: unchanged, no overflow.
- tRFC: ack_ok loads the tRFC counter with C_TRFC_CYCLES-1 and sets rank_busy the next cycle. The counter decrements to 0. rank_busy deasserts the cycle after the counter reads 0, so rank_busy stays high for exactly C_TRFC_CYCLES cycles.
- ref_req[i] = registered (pending != 0) & ~rank_busy[i] & enable_q. There is no combinational path from ref_ack to ref_req. ref_req drops the cycle after ack_ok.
- ref_urgent[i] = registered (pending >= C_URGENT_THRESH), independent of busy.
- Ranks are fully independent. Simultaneous acks to multiple ranks are legal.
- Widths: pending is a 4-bit field per rank; unused upper values are unreachable. Counters are C_CNT_WIDTH bits; parameter legality is checked by elaboration-time assertions.

Test Plan:
- C_CS_WIDTH=1, TREFI=100, TRFC=10; reset, then enable high at cycle 0, no ack -> first tick at cycle 100; ref_req high at cycle 101; pending=1.
- Same config; ack 5 cycles after ref_req rises -> pending 1->0; ref_req low the next cycle; rank_busy high for exactly 10 cycles; no new req until the next tick.
- No acks for 9 tREFI periods, MAX_POSTPONE=8, URGENT=7 -> ref_urgent rises at the 7th tick; pending saturates at 8; overflow sets at the 9th tick and stays set after later acks.
- Ack coincident with a tick while pending=3 -> pending stays 3; rank_busy asserts; overflow stays 0.
- C_CS_WIDTH=4, TREFI=100 -> first ticks for ranks 0..3 at cycles 100, 75, 50, 25; acks to ranks 1 and 2 in the same cycle both accepted.
- Mid-tRFC enable low at pending=2, then core_arstn pulsed low mid-window -> enable low clears pending to 0 while rank_busy finishes its count; the reset clears every output asynchronously within the same cycle.

Source files
------------

// File: rtl/refresh_scheduler.sv
// rtl/refresh_scheduler.sv - per-rank DDR refresh timer and postponement tracker
//
// Counts tREFI independently for each rank, with the ranks' first intervals
// staggered so they do not all come due together. Owed refreshes accumulate
// up to C_MAX_POSTPONE. Normal and urgent requests go to main_control, and
// each rank is held busy for tRFC after every accepted REF.
//
// Ports:
//   core_clk          : core clock
//   core_arstn        : asynchronous active-low reset
//   enable            : refresh tracking enable (init done / not in self-refresh)
//   ref_ack[i]        : REF issued to rank i this cycle (one-cycle pulse)
//   ref_req[i]        : rank i owes a refresh and is not inside tRFC
//   ref_urgent[i]     : rank i owed count >= C_URGENT_THRESH
//   rank_busy[i]      : rank i inside its tRFC window
//   pending[4i+3:4i]  : owed refresh count of rank i
//   overflow[i]       : sticky, a tick arrived while rank i was at C_MAX_POSTPONE

module refresh_scheduler #(
  parameter int C_CS_WIDTH      = 1,
  parameter int C_CNT_WIDTH     = 16,
  parameter int C_TREFI_CYCLES  = 6240,
  parameter int C_TRFC_CYCLES   = 128,
  parameter int C_MAX_POSTPONE  = 8,
  parameter int C_URGENT_THRESH = 7
) (
  input  logic                      core_clk,
  input  logic                      core_arstn,
  input  logic                      enable,
  input  logic [C_CS_WIDTH-1:0]     ref_ack,
  output logic [C_CS_WIDTH-1:0]     ref_req,
  output logic [C_CS_WIDTH-1:0]     ref_urgent,
  output logic [C_CS_WIDTH-1:0]     rank_busy,
  output logic [4*C_CS_WIDTH-1:0]   pending,
  output logic [C_CS_WIDTH-1:0]     overflow
);

  if (C_CS_WIDTH < 1 || C_CS_WIDTH > 8) begin : g_bad_cs
    $error("refresh_scheduler: C_CS_WIDTH must be 1..8");
  end
  if (C_TREFI_CYCLES < 2 || C_TREFI_CYCLES > (2 ** C_CNT_WIDTH) - 1) begin : g_bad_trefi
    $error("refresh_scheduler: C_TREFI_CYCLES out of range");
  end
  if (C_TRFC_CYCLES < 1 || C_TRFC_CYCLES > C_TREFI_CYCLES - 1) begin : g_bad_trfc
    $error("refresh_scheduler: C_TRFC_CYCLES out of range");
  end
  if (C_MAX_POSTPONE < 1 || C_MAX_POSTPONE > 15) begin : g_bad_max
    $error("refresh_scheduler: C_MAX_POSTPONE must be 1..15");
  end
  if (C_URGENT_THRESH < 1 || C_URGENT_THRESH > C_MAX_POSTPONE) begin : g_bad_urg
    $error("refresh_scheduler: C_URGENT_THRESH must be 1..C_MAX_POSTPONE");
  end

  localparam int                     STAGGER    = C_TREFI_CYCLES / C_CS_WIDTH;
  localparam logic [C_CNT_WIDTH-1:0] TREFI_LAST = C_CNT_WIDTH'(C_TREFI_CYCLES - 1);
  localparam logic [C_CNT_WIDTH-1:0] TRFC_LAST  = C_CNT_WIDTH'(C_TRFC_CYCLES - 1);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE    = C_CNT_WIDTH'(1);
  localparam logic [3:0]             MAX_PEND   = 4'(C_MAX_POSTPONE);
  localparam logic [3:0]             URG_PEND   = 4'(C_URGENT_THRESH);

  logic enable_q;
  logic enable_rise;

  assign enable_rise = enable & ~enable_q;

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;
    end
  end

  for (genvar i = 0; i < C_CS_WIDTH; i++) begin : g_rank
    // Each rank starts a different fraction of tREFI into its first interval.
    localparam logic [C_CNT_WIDTH-1:0] INTV_LOAD =
      C_CNT_WIDTH'(C_TREFI_CYCLES - 1 - i * STAGGER);

    logic [C_CNT_WIDTH-1:0] intv_q, intv_d;
    logic [C_CNT_WIDTH-1:0] trfc_q, trfc_d;
    logic [3:0]             pend_q, pend_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic                   req_q, urg_q;
    logic                   tick, ack_ok;

    // The request is registered, so ack_ok never loops back into ref_req
    // within a cycle.
    assign ack_ok = ref_ack[i] & req_q;
    assign tick   = enable & ~enable_rise & (intv_q == '0);

    always_comb begin
      intv_d = intv_q;
      if (enable_rise) begin
        intv_d = INTV_LOAD;
      end else if (enable) begin
        intv_d = (intv_q == '0) ? TREFI_LAST : intv_q - CNT_ONE;
      end

      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (!enable) begin
        // Leaving normal operation (self-refresh/reinit) forgives owed refreshes.
        pend_d = 4'd0;
      end else if (tick && !ack_ok) begin
        if (pend_q == MAX_PEND) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + 4'd1;
        end
      end else if (ack_ok && !tick && pend_q != 4'd0) begin
        // The guard covers the one-cycle request lag after the last owed REF.
        pend_d = pend_q - 4'd1;
      end

      trfc_d = trfc_q;
      busy_d = busy_q;
      if (ack_ok) begin
        trfc_d = TRFC_LAST;
        busy_d = 1'b1;
      end else if (busy_q) begin
        if (trfc_q == '0) begin
          busy_d = 1'b0;
        end else begin
          trfc_d = trfc_q - CNT_ONE;
        end
      end
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
      if (!core_arstn) begin
        intv_q <= '0;
        trfc_q <= '0;
        pend_q <= 4'd0;
        busy_q <= 1'b0;
        ovf_q  <= 1'b0;
        req_q  <= 1'b0;
        urg_q  <= 1'b0;
      end else begin
        intv_q <= intv_d;
        trfc_q <= trfc_d;
        pend_q <= pend_d;
        busy_q <= busy_d;
        ovf_q  <= ovf_d;
        req_q  <= (pend_q != 4'd0) & ~busy_q & enable_q;
        urg_q  <= (pend_q >= URG_PEND);
      end
    end

    assign ref_req[i]        = req_q;
    assign ref_urgent[i]     = urg_q;
    assign rank_busy[i]      = busy_q;
    assign overflow[i]       = ovf_q;
    assign pending[4*i +: 4] = pend_q;
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// tb/tb_refresh_scheduler.sv - scoreboard bench for refresh_scheduler
//
// Four ranks, tREFI=100, tRFC=10, max postpone 8, urgent threshold 7.
// Expected values are cycle-stamped and queued by the stimulus process. A
// monitor pops and compares them when the DUT reaches that cycle.

`timescale 1ns/1ps

module tb_refresh_scheduler;

  localparam int NR = 4;
  localparam int S_REQ  = 0;
  localparam int S_URG  = 1;
  localparam int S_BUSY = 2;
  localparam int S_PEND = 3;
  localparam int S_OVF  = 4;

  logic            core_clk   = 1'b0;
  logic            core_arstn = 1'b0;
  logic            enable     = 1'b0;
  logic [NR-1:0]   ref_ack    = '0;
  logic [NR-1:0]   ref_req, ref_urgent, rank_busy, overflow;
  logic [4*NR-1:0] pending;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int cyc;
    int sig;
    int rank;
    int val;
  } exp_t;

  exp_t exp_q[$];
  event sample_now;

  refresh_scheduler #(
    .C_CS_WIDTH     (NR),
    .C_CNT_WIDTH    (16),
    .C_TREFI_CYCLES (100),
    .C_TRFC_CYCLES  (10),
    .C_MAX_POSTPONE (8),
    .C_URGENT_THRESH(7)
  ) dut (
    .core_clk  (core_clk),
    .core_arstn(core_arstn),
    .enable    (enable),
    .ref_ack   (ref_ack),
    .ref_req   (ref_req),
    .ref_urgent(ref_urgent),
    .rank_busy (rank_busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) cyc <= cyc + 1;

  function automatic int act(int s, int r);
    case (s)
      S_REQ:   return int'(ref_req[r]);
      S_URG:   return int'(ref_urgent[r]);
      S_BUSY:  return int'(rank_busy[r]);
      S_PEND:  return int'(pending[4*r +: 4]);
      default: return int'(overflow[r]);
    endcase
  endfunction

  function automatic string sname(int s);
    case (s)
      S_REQ:   return "ref_req";
      S_URG:   return "ref_urgent";
      S_BUSY:  return "rank_busy";
      S_PEND:  return "pending";
      default: return "overflow";
    endcase
  endfunction

  task automatic expect_at(input int c, input int s, input int r, input int v);
    exp_t e;
    e.cyc  = c;
    e.sig  = s;
    e.rank = r;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_all_zero(input int c);
    for (int r = 0; r < NR; r++)
      for (int s = 0; s <= S_OVF; s++)
        expect_at(c, s, r, 0);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge core_clk);
  endtask

  // Input is sampled by the DUT at posedge number c.
  task automatic ack_at(input int c, input logic [NR-1:0] m);
    wait_to(c - 1);
    ref_ack = m;
    @(negedge core_clk);
    ref_ack = '0;
  endtask

  task automatic enable_at(input int c, input logic v);
    wait_to(c - 1);
    enable = v;
  endtask

  // Monitor: compares every queued expectation whose cycle has arrived.
  initial begin
    forever begin
      @(negedge core_clk or sample_now);
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
        if (exp_q[k].cyc <= cyc) begin
          checks++;
          if (exp_q[k].cyc < cyc) begin
            errors++;
            $display("FAIL late_%s[%0d]: due cycle %0d, seen at cycle %0d",
                     sname(exp_q[k].sig), exp_q[k].rank, exp_q[k].cyc, cyc);
          end else if (act(exp_q[k].sig, exp_q[k].rank) != exp_q[k].val) begin
            errors++;
            $display("FAIL %s[%0d] @cycle %0d: got %0d, expected %0d",
                     sname(exp_q[k].sig), exp_q[k].rank, cyc,
                     act(exp_q[k].sig, exp_q[k].rank), exp_q[k].val);
          end
          exp_q.delete(k);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    int f;

    repeat (3) @(negedge core_clk);
    core_arstn = 1'b1;
    expect_all_zero(cyc + 1);
    repeat (2) @(negedge core_clk);

    // Phase A: enable first sampled at posedge e.
    e = cyc + 2;
    expect_at(e + 25,  S_PEND, 3, 1);
    expect_at(e + 25,  S_REQ,  3, 0);
    expect_at(e + 26,  S_REQ,  3, 1);
    expect_at(e + 50,  S_PEND, 2, 1);
    expect_at(e + 51,  S_REQ,  2, 1);
    expect_at(e + 75,  S_PEND, 1, 1);
    expect_at(e + 76,  S_REQ,  1, 1);
    expect_at(e + 99,  S_PEND, 0, 0);
    expect_at(e + 100, S_PEND, 0, 1);
    expect_at(e + 100, S_REQ,  0, 0);
    expect_at(e + 101, S_REQ,  0, 1);
    // Rank 0 acked 5 cycles after its request rose.
    expect_at(e + 106, S_PEND, 0, 0);
    expect_at(e + 106, S_BUSY, 0, 1);
    expect_at(e + 107, S_REQ,  0, 0);
    expect_at(e + 115, S_BUSY, 0, 1);
    expect_at(e + 116, S_BUSY, 0, 0);
    expect_at(e + 116, S_REQ,  0, 0);
    expect_at(e + 199, S_REQ,  0, 0);
    expect_at(e + 200, S_PEND, 0, 1);
    expect_at(e + 201, S_REQ,  0, 1);
    // Ranks 1 and 2 acked together.
    expect_at(e + 110, S_PEND, 1, 0);
    expect_at(e + 110, S_PEND, 2, 0);
    expect_at(e + 110, S_BUSY, 1, 1);
    expect_at(e + 110, S_BUSY, 2, 1);
    expect_at(e + 111, S_REQ,  1, 0);
    expect_at(e + 111, S_REQ,  2, 0);
    expect_at(e + 119, S_BUSY, 1, 1);
    expect_at(e + 120, S_BUSY, 2, 0);
    // Rank 2 acked on the same cycle as its tick, pending 3.
    expect_at(e + 449, S_PEND, 2, 3);
    expect_at(e + 450, S_PEND, 2, 3);
    expect_at(e + 450, S_BUSY, 2, 1);
    expect_at(e + 450, S_OVF,  2, 0);
    expect_at(e + 451, S_REQ,  2, 0);
    // Rank 3 never acked: urgent, saturation, overflow.
    expect_at(e + 624, S_PEND, 3, 6);
    expect_at(e + 625, S_PEND, 3, 7);
    expect_at(e + 625, S_URG,  3, 0);
    expect_at(e + 626, S_URG,  3, 1);
    expect_at(e + 725, S_PEND, 3, 8);
    expect_at(e + 725, S_OVF,  3, 0);
    expect_at(e + 824, S_OVF,  3, 0);
    expect_at(e + 825, S_PEND, 3, 8);
    expect_at(e + 825, S_OVF,  3, 1);
    expect_at(e + 830, S_PEND, 3, 7);
    expect_at(e + 830, S_BUSY, 3, 1);
    expect_at(e + 831, S_OVF,  3, 1);
    expect_at(e + 831, S_URG,  3, 1);
    expect_at(e + 840, S_REQ,  3, 0);
    expect_at(e + 841, S_REQ,  3, 1);
    expect_at(e + 846, S_PEND, 3, 6);
    expect_at(e + 846, S_URG,  3, 0);
    expect_at(e + 846, S_OVF,  3, 1);
    // Enable drop clears pending; overflow is sticky.
    expect_at(e + 869, S_PEND, 1, 7);
    expect_at(e + 870, S_URG,  1, 1);
    for (int r = 0; r < NR; r++) begin
      expect_at(e + 870, S_PEND, r, 0);
      expect_at(e + 871, S_REQ,  r, 0);
    end
    expect_at(e + 871, S_URG,  1, 0);
    expect_at(e + 870, S_OVF,  3, 1);

    enable_at(e, 1'b1);
    ack_at(e + 106, 4'b0001);
    ack_at(e + 110, 4'b0110);
    ack_at(e + 450, 4'b0100);
    ack_at(e + 830, 4'b1000);
    ack_at(e + 845, 4'b1000);
    enable_at(e + 870, 1'b0);

    // Phase B: re-enable restarts the staggered intervals.
    f = e + 880;
    expect_at(f + 25,  S_PEND, 3, 1);
    expect_at(f + 26,  S_REQ,  3, 1);
    expect_at(f + 125, S_PEND, 3, 2);
    expect_at(f + 225, S_PEND, 3, 3);
    expect_at(f + 227, S_PEND, 3, 2);
    expect_at(f + 227, S_BUSY, 3, 1);
    expect_at(f + 229, S_PEND, 3, 2);
    expect_at(f + 229, S_PEND, 2, 2);
    expect_at(f + 230, S_PEND, 3, 0);
    expect_at(f + 230, S_PEND, 2, 0);
    expect_at(f + 230, S_BUSY, 3, 1);
    expect_at(f + 231, S_REQ,  2, 0);
    expect_at(f + 231, S_REQ,  3, 0);
    expect_at(f + 233, S_BUSY, 3, 1);
    expect_at(f + 233, S_OVF,  3, 1);

    enable_at(f, 1'b1);
    ack_at(f + 227, 4'b1000);
    enable_at(f + 230, 1'b0);

    // Asynchronous reset mid-tRFC, between clock edges.
    wait_to(f + 233);
    #2;
    core_arstn = 1'b0;
    #1;
    expect_all_zero(cyc);
    -> sample_now;
    #1;
    core_arstn = 1'b1;
    expect_at(f + 234, S_BUSY, 3, 0);
    expect_at(f + 234, S_OVF,  3, 0);
    expect_at(f + 234, S_PEND, 3, 0);

    wait_to(f + 240);
    foreach (exp_q[k]) begin
      checks++;
      errors++;
      $display("FAIL unchecked_%s[%0d]: due cycle %0d, expected %0d",
               sname(exp_q[k].sig), exp_q[k].rank, exp_q[k].cyc, exp_q[k].val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
